// File: rtl/servo_pwm_multi.sv
// N-channel hobby-servo PWM generator: shared tic divider and frame counter,
// per-channel clamp, hold-on-disable, frame-synchronous position update and optional slew limit.
module servo_pwm_multi #(
  parameter int unsigned NCH        = 4,
  parameter int unsigned POS_W      = 8,
  parameter int unsigned TIC_DIV    = 94,
  parameter int unsigned FRAME_TICS = 2048,
  parameter int unsigned OFFSET     = 46,
  parameter int unsigned MIN_POS    = 0,
  parameter int unsigned MAX_POS    = 255,
  parameter int unsigned HOME_POS   = 127,
  parameter int unsigned SLEW_STEP  = 0
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NCH*POS_W-1:0]   angle,
  input  logic [NCH-1:0]         enable_mov,
  output logic [NCH-1:0]         servo,
  output logic                   frame_start,
  output logic [NCH-1:0]         busy
);

  localparam int unsigned DIV_W    = (TIC_DIV > 2) ? $clog2(TIC_DIV) : 1;
  localparam int unsigned FC_W     = (FRAME_TICS > 2) ? $clog2(FRAME_TICS) : 1;
  localparam int unsigned STEP_LIM = (SLEW_STEP > (1 << POS_W)) ? (1 << POS_W) : SLEW_STEP;

  localparam logic [POS_W-1:0] HOME_P = POS_W'(HOME_POS);
  localparam logic [POS_W-1:0] MIN_P  = POS_W'(MIN_POS);
  localparam logic [POS_W-1:0] MAX_P  = POS_W'(MAX_POS);
  localparam logic [POS_W:0]   STEP_E = (POS_W+1)'(STEP_LIM);

  if (MAX_POS + OFFSET >= FRAME_TICS) begin : g_chk_frame
    $error("servo_pwm_multi: MAX_POS+OFFSET must be below FRAME_TICS");
  end
  if ((MIN_POS > HOME_POS) || (HOME_POS > MAX_POS)) begin : g_chk_home
    $error("servo_pwm_multi: HOME_POS must lie within MIN_POS..MAX_POS");
  end
  if (MAX_POS >= (1 << POS_W)) begin : g_chk_max
    $error("servo_pwm_multi: MAX_POS does not fit in POS_W bits");
  end
  if (TIC_DIV < 2) begin : g_chk_div
    $error("servo_pwm_multi: TIC_DIV must be at least 2");
  end

  logic [DIV_W-1:0] r_div;
  logic [FC_W-1:0]  r_frame_cnt;
  logic             r_frame_start;
  logic             w_tic;
  logic             w_wrap;

  assign w_tic  = (r_div == DIV_W'(TIC_DIV - 1));
  assign w_wrap = w_tic && (r_frame_cnt == FC_W'(FRAME_TICS - 1));

  // Shared timebase; frame_start rises together with frame_cnt returning to 0
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_div         <= '0;
      r_frame_cnt   <= '0;
      r_frame_start <= 1'b0;
    end else begin
      r_div         <= w_tic ? '0 : r_div + DIV_W'(1);
      r_frame_start <= w_wrap;
      if (w_wrap)     r_frame_cnt <= '0;
      else if (w_tic) r_frame_cnt <= r_frame_cnt + FC_W'(1);
    end
  end

  assign frame_start = r_frame_start;

  for (genvar i = 0; i < NCH; i++) begin : g_ch
    logic [POS_W-1:0] w_angle;
    logic [POS_W-1:0] w_lo;
    logic [POS_W-1:0] w_clamped;
    logic [POS_W-1:0] w_cur_next;
    logic [FC_W-1:0]  w_pulse_end;
    logic [POS_W-1:0] r_target;
    logic [POS_W-1:0] r_cur;
    logic             r_servo;
    logic             r_busy;

    assign w_angle = angle[i*POS_W +: POS_W];

    if (MIN_POS > 0) begin : g_lo
      assign w_lo = (w_angle < MIN_P) ? MIN_P : w_angle;
    end else begin : g_nolo
      assign w_lo = w_angle;
    end

    if (MAX_POS < (1 << POS_W) - 1) begin : g_hi
      assign w_clamped = (w_lo > MAX_P) ? MAX_P : w_lo;
    end else begin : g_nohi
      assign w_clamped = w_lo;
    end

    if (SLEW_STEP == 0) begin : g_jump
      assign w_cur_next = r_target;
    end else begin : g_slew
      logic [POS_W:0] w_cur_e;
      logic [POS_W:0] w_tgt_e;
      logic [POS_W:0] w_diff;
      logic [POS_W:0] w_delta;

      // Step toward target by at most STEP_E; the delta never exceeds the gap
      always_comb begin
        w_cur_e    = {1'b0, r_cur};
        w_tgt_e    = {1'b0, r_target};
        w_diff     = '0;
        w_delta    = '0;
        w_cur_next = r_cur;
        if (w_tgt_e > w_cur_e) begin
          w_diff     = w_tgt_e - w_cur_e;
          w_delta    = (w_diff > STEP_E) ? STEP_E : w_diff;
          w_cur_next = POS_W'(w_cur_e + w_delta);
        end else begin
          w_diff     = w_cur_e - w_tgt_e;
          w_delta    = (w_diff > STEP_E) ? STEP_E : w_diff;
          w_cur_next = POS_W'(w_cur_e - w_delta);
        end
      end
    end

    assign w_pulse_end = FC_W'(r_cur) + FC_W'(OFFSET);

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        r_target <= HOME_P;
        r_cur    <= HOME_P;
        r_servo  <= 1'b0;
        r_busy   <= 1'b0;
      end else begin
        if (enable_mov[i]) r_target <= w_clamped;
        if (r_frame_start) r_cur    <= w_cur_next;
        r_servo <= (r_frame_cnt < w_pulse_end);
        r_busy  <= (r_cur != r_target);
      end
    end

    assign servo[i] = r_servo;
    assign busy[i]  = r_busy;
  end

endmodule
